commit_unit_n: RTL and testbench

In-order, registered, N-wide commit stage for the circular reorder buffer (ROB). It keeps the ROB head pointer with a wrap bit and each cycle retires the longest committable run of up to COMMIT_WIDTH entries starting at the head. Retired results go to the register file; at most one store per cycle goes to the store buffer through a valid/ready handshake. It sits between the ROB and the register-file/store-buffer write ports and replaces the combinational two-entry max-tag commit.

---
 rtl/commit_unit_n_pkg.sv | 23 ++
 rtl/commit_unit_n_if.sv | 38 +++
 rtl/commit_unit_n_window_select.sv | 58 +++++
 rtl/commit_unit_n.sv | 132 +++++++++++++
 tb/tb_commit_unit_n.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_unit_n_pkg.sv
// Shared types for the N-wide ROB commit stage: ROB entry layout, unit kinds,
// load/store widths and the commit FSM encoding.
package commit_unit_n_pkg;
    localparam int BUF_SIZE     = 8;
    localparam int BUF_SIZE_LOG = $clog2(BUF_SIZE);

    typedef enum logic [1:0] {S_EMPTY, S_ISSUED, S_EXECUTED} e_state_t;
    typedef enum logic [1:0] {ALU, LOAD, STORE, BRANCH} unit_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} ldst_mode;

    // result doubles as the store data for STORE entries
    typedef struct packed {
        e_state_t              e_state;
        unit_t                 unit_kind;
        logic [BUF_SIZE_LOG:0] tag;
        logic [4:0]            dest;
        logic [31:0]           result;
        logic [31:0]           addr;
        ldst_mode              mode;
    } entry_t;

    typedef enum logic {CU_IDLE, CU_STORE_WAIT} cu_state_t;
endpackage

// File: rtl/commit_unit_n_if.sv
// Bundle between the commit stage and the ROB / register file / store buffer.
// slave = commit unit side, master = surrounding pipeline side.
interface commit_unit_n_if #(
    parameter int BUF_SIZE     = commit_unit_n_pkg::BUF_SIZE,
    parameter int BUF_SIZE_LOG = $clog2(BUF_SIZE),
    parameter int COMMIT_WIDTH = 4
);
    import commit_unit_n_pkg::*;
    localparam int TAG_W = BUF_SIZE_LOG + 1;
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    entry_t                  entries [BUF_SIZE];
    logic                    flush;
    logic [TAG_W-1:0]        flush_tag;
    logic                    store_ready;
    logic [COMMIT_WIDTH-1:0] reg_we;
    logic [4:0]              reg_addr [COMMIT_WIDTH];
    logic [31:0]             reg_data [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] commit_valid;
    logic [TAG_W-1:0]        commit_tags [COMMIT_WIDTH];
    logic [CNT_W-1:0]        commit_count;
    logic [TAG_W-1:0]        head_tag;
    logic                    store_valid;
    ldst_mode                store_mode;
    logic [31:0]             store_addr;
    logic [31:0]             store_data;

    modport slave (
        input  entries, flush, flush_tag, store_ready,
        output reg_we, reg_addr, reg_data, commit_valid, commit_tags, commit_count,
               head_tag, store_valid, store_mode, store_addr, store_data
    );
    modport master (
        output entries, flush, flush_tag, store_ready,
        input  reg_we, reg_addr, reg_data, commit_valid, commit_tags, commit_count,
               head_tag, store_valid, store_mode, store_addr, store_data
    );
endinterface

// File: rtl/commit_unit_n_window_select.sv
// Combinational window scan: finds the longest committable run from the head,
// allowing only the first store in the window to retire.
module commit_window_select #(
    parameter int BUF_SIZE     = commit_unit_n_pkg::BUF_SIZE,
    parameter int BUF_SIZE_LOG = $clog2(BUF_SIZE),
    parameter int COMMIT_WIDTH = 4,
    localparam int TAG_W  = BUF_SIZE_LOG + 1,
    localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1),
    localparam int LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  commit_unit_n_pkg::entry_t entries [BUF_SIZE],
    input  logic [TAG_W-1:0]          head_tag,
    input  logic                      store_blocked,
    output logic [COMMIT_WIDTH-1:0]   commit_mask,
    output commit_unit_n_pkg::entry_t lane_entries [COMMIT_WIDTH],
    output logic [LANE_W-1:0]         store_lane,
    output logic                      store_found,
    output logic [CNT_W-1:0]          count
);
    import commit_unit_n_pkg::*;

    logic [COMMIT_WIDTH-1:0] eligible;
    logic [COMMIT_WIDTH-1:0] is_store;
    logic                    run;

    genvar gi;
    generate
        for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane
            logic [BUF_SIZE_LOG-1:0] slot;
            // slot index wraps naturally; the expected tag carries the phase bit
            assign slot              = head_tag[BUF_SIZE_LOG-1:0] + BUF_SIZE_LOG'(gi);
            assign lane_entries[gi]  = entries[slot];
            assign eligible[gi]      = (entries[slot].e_state == S_EXECUTED) &&
                                       (entries[slot].tag == head_tag + TAG_W'(gi));
            assign is_store[gi]      = (entries[slot].unit_kind == STORE);
        end
    endgenerate

    always_comb begin
        commit_mask = '0;
        store_lane  = '0;
        store_found = 1'b0;
        count       = '0;
        run         = !store_blocked;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (run && eligible[k] && !(is_store[k] && store_found)) begin
                commit_mask[k] = 1'b1;
                count          = count + CNT_W'(1);
                if (is_store[k]) begin
                    store_found = 1'b1;
                    store_lane  = LANE_W'(k);
                end
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/commit_unit_n.sv
// Registered N-wide in-order commit stage: head pointer, store handshake FSM
// and the register-file / store-buffer output registers.
module commit_unit_n #(
    parameter int BUF_SIZE     = commit_unit_n_pkg::BUF_SIZE,
    parameter int BUF_SIZE_LOG = $clog2(BUF_SIZE),
    parameter int COMMIT_WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    commit_unit_n_if.slave cu
);
    import commit_unit_n_pkg::*;
    localparam int TAG_W  = BUF_SIZE_LOG + 1;
    localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    cu_state_t               state_reg, state_next;
    logic                    store_blocked;
    logic [TAG_W-1:0]        head_reg;
    logic [COMMIT_WIDTH-1:0] mask;
    entry_t                  lane_entries [COMMIT_WIDTH];
    logic [LANE_W-1:0]       store_lane;
    logic                    store_found;
    logic [CNT_W-1:0]        count;

    logic [COMMIT_WIDTH-1:0] we_next, reg_we_reg, commit_valid_reg;
    logic [4:0]              addr_next [COMMIT_WIDTH];
    logic [4:0]              reg_addr_reg [COMMIT_WIDTH];
    logic [31:0]             data_next [COMMIT_WIDTH];
    logic [31:0]             reg_data_reg [COMMIT_WIDTH];
    logic [TAG_W-1:0]        tag_next [COMMIT_WIDTH];
    logic [TAG_W-1:0]        commit_tags_reg [COMMIT_WIDTH];
    logic [CNT_W-1:0]        commit_count_reg;
    logic                    store_valid_reg;
    ldst_mode                store_mode_reg;
    logic [31:0]             store_addr_reg, store_data_reg;

    commit_window_select #(
        .BUF_SIZE(BUF_SIZE), .BUF_SIZE_LOG(BUF_SIZE_LOG), .COMMIT_WIDTH(COMMIT_WIDTH)
    ) u_select (
        .entries(cu.entries), .head_tag(head_reg), .store_blocked(store_blocked),
        .commit_mask(mask), .lane_entries(lane_entries), .store_lane(store_lane),
        .store_found(store_found), .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= CU_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (cu.flush) begin
            state_next = CU_IDLE;
        end else begin
            case (state_reg)
                CU_IDLE:       if (store_valid_reg && !cu.store_ready) state_next = CU_STORE_WAIT;
                CU_STORE_WAIT: if (cu.store_ready) state_next = CU_IDLE;
                default:       state_next = CU_IDLE;
            endcase
        end
    end

    // An unaccepted store freezes the whole window so its outputs stay stable.
    always_comb begin
        store_blocked = 1'b0;
        case (state_reg)
            CU_IDLE:       store_blocked = store_valid_reg && !cu.store_ready;
            CU_STORE_WAIT: store_blocked = !cu.store_ready;
            default:       store_blocked = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane_next
            assign we_next[gi]   = mask[gi] && (lane_entries[gi].unit_kind != STORE) &&
                                   (lane_entries[gi].dest != 5'd0);
            assign addr_next[gi] = we_next[gi] ? lane_entries[gi].dest : 5'd0;
            assign data_next[gi] = we_next[gi] ? lane_entries[gi].result : 32'd0;
            assign tag_next[gi]  = mask[gi] ? lane_entries[gi].tag : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || cu.flush) begin
            head_reg         <= rst ? '0 : cu.flush_tag;
            commit_valid_reg <= '0;
            reg_we_reg       <= '0;
            commit_count_reg <= '0;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                reg_addr_reg[k]    <= '0;
                reg_data_reg[k]    <= '0;
                commit_tags_reg[k] <= '0;
            end
            store_valid_reg <= 1'b0;
            store_mode_reg  <= WORD;
            store_addr_reg  <= '0;
            store_data_reg  <= '0;
        end else begin
            head_reg         <= head_reg + TAG_W'(count);
            commit_valid_reg <= mask;
            reg_we_reg       <= we_next;
            commit_count_reg <= count;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                reg_addr_reg[k]    <= addr_next[k];
                reg_data_reg[k]    <= data_next[k];
                commit_tags_reg[k] <= tag_next[k];
            end
            if (store_found) begin
                store_valid_reg <= 1'b1;
                store_mode_reg  <= lane_entries[store_lane].mode;
                store_addr_reg  <= lane_entries[store_lane].addr;
                store_data_reg  <= lane_entries[store_lane].result;
            end else if (store_valid_reg && cu.store_ready) begin
                store_valid_reg <= 1'b0;
            end
        end
    end

    assign cu.head_tag     = head_reg;
    assign cu.commit_valid = commit_valid_reg;
    assign cu.reg_we       = reg_we_reg;
    assign cu.reg_addr     = reg_addr_reg;
    assign cu.reg_data     = reg_data_reg;
    assign cu.commit_tags  = commit_tags_reg;
    assign cu.commit_count = commit_count_reg;
    assign cu.store_valid  = store_valid_reg;
    assign cu.store_mode   = store_mode_reg;
    assign cu.store_addr   = store_addr_reg;
    assign cu.store_data   = store_data_reg;
endmodule

// File: tb/tb_commit_unit_n.sv
// Scoreboard bench for commit_unit_n: a ROB-level reference model predicts each
// cycle's registered outputs; a monitor compares them after every clock edge.
module tb_commit_unit_n;
    import commit_unit_n_pkg::*;
    localparam int CW = 4;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_unit_n_if #(.BUF_SIZE(NB), .BUF_SIZE_LOG(3), .COMMIT_WIDTH(CW)) cu_bus ();
    commit_unit_n #(.BUF_SIZE(NB), .BUF_SIZE_LOG(3), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cu(cu_bus)
    );

    typedef struct packed {
        logic [CW-1:0]       cv;
        logic [CW-1:0]       we;
        logic [CW-1:0][4:0]  addr;
        logic [CW-1:0][31:0] data;
        logic [CW-1:0][3:0]  tag;
        logic [2:0]          cnt;
        logic [3:0]          head;
        logic                sv;
        ldst_mode            mode;
        logic [31:0]         saddr;
        logic [31:0]         sdata;
    } exp_t;

    exp_t     exp_q[$];
    int       free_q[$];
    entry_t   rob [NB];
    int       tail;
    int       total = 0;
    int       bad = 0;

    // reference state: head position and the store held at the store-buffer port
    int          m_head;
    logic        m_sv;
    ldst_mode    m_mode;
    logic [31:0] m_saddr, m_sdata;

    logic       rst_i, flush_i, sready_i;
    logic [3:0] ftag_i;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk_entry(unit_t u, int tag, int dest, logic [31:0] val);
        entry_t x;
        x.e_state   = S_EXECUTED;
        x.unit_kind = u;
        x.tag       = 4'(tag);
        x.dest      = 5'(dest);
        x.result    = val;
        x.addr      = val + 32'h1000;
        x.mode      = WORD;
        return x;
    endfunction

    function automatic entry_t rand_entry(int tag);
        entry_t x;
        int u;
        u = $urandom_range(0, 7);
        x.e_state = S_ISSUED;
        case (u)
            0, 1, 2, 3: x.unit_kind = ALU;
            4:          x.unit_kind = LOAD;
            5:          x.unit_kind = BRANCH;
            default:    x.unit_kind = STORE;
        endcase
        x.tag    = 4'(tag);
        x.dest   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        x.result = $urandom();
        x.addr   = $urandom();
        x.mode   = ldst_mode'($urandom_range(0, 2));
        return x;
    endfunction

    // Present the ROB, then work out what the commit stage must show after the edge.
    task automatic drive_and_model();
        exp_t   e;
        entry_t x;
        logic   stalled, seen_store;
        int     n;
        for (int s = 0; s < NB; s++) cu_bus.entries[s] = rob[s];
        rst                = rst_i;
        cu_bus.flush       = flush_i;
        cu_bus.flush_tag   = ftag_i;
        cu_bus.store_ready = sready_i;
        e = '0;
        if (rst_i || flush_i) begin
            m_head  = rst_i ? 0 : int'(ftag_i);
            m_sv    = 1'b0;
            m_mode  = WORD;
            m_saddr = '0;
            m_sdata = '0;
        end else begin
            stalled    = m_sv && !sready_i;
            seen_store = 1'b0;
            n          = 0;
            if (m_sv && sready_i) m_sv = 1'b0;
            if (!stalled) begin
                for (int k = 0; k < CW; k++) begin
                    x = rob[(m_head + k) % NB];
                    if (x.e_state != S_EXECUTED || int'(x.tag) != (m_head + k) % 16) break;
                    if (x.unit_kind == STORE) begin
                        if (seen_store) break;
                        seen_store = 1'b1;
                        m_sv    = 1'b1;
                        m_mode  = x.mode;
                        m_saddr = x.addr;
                        m_sdata = x.result;
                    end else if (x.dest != 5'd0) begin
                        e.we[k]   = 1'b1;
                        e.addr[k] = x.dest;
                        e.data[k] = x.result;
                    end
                    e.cv[k]  = 1'b1;
                    e.tag[k] = x.tag;
                    n++;
                    free_q.push_back((m_head + k) % NB);
                end
            end
            e.cnt  = 3'(n);
            m_head = (m_head + n) % 16;
        end
        e.head  = 4'(m_head);
        e.sv    = m_sv;
        e.mode  = m_mode;
        e.saddr = m_saddr;
        e.sdata = m_sdata;
        exp_q.push_back(e);
        if (rst_i || flush_i) begin
            for (int s = 0; s < NB; s++) rob[s].e_state = S_EMPTY;
            tail = m_head;
        end
    endtask

    task automatic randomize_inputs();
        int r;
        r        = $urandom_range(0, 199);
        rst_i    = (r == 0);
        flush_i  = (r >= 1 && r <= 4);
        ftag_i   = 4'($urandom_range(0, 15));
        sready_i = ($urandom_range(0, 9) < 6);
        if (!rst_i && !flush_i) begin
            while (((tail - m_head + 16) % 16) < NB && $urandom_range(0, 2) != 0) begin
                rob[tail % NB] = rand_entry(tail);
                tail = (tail + 1) % 16;
            end
            for (int s = 0; s < NB; s++)
                if (rob[s].e_state == S_ISSUED && $urandom_range(0, 1) == 1)
                    rob[s].e_state = S_EXECUTED;
        end
    endtask

    task automatic cycle(bit rnd);
        @(negedge clk);
        if (rnd) randomize_inputs();
        drive_and_model();
        foreach (free_q[i]) rob[free_q[i]].e_state = S_EMPTY;
        free_q.delete();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // monitor: one expectation per clock edge once stimulus has started
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("head_tag", 64'(cu_bus.head_tag), 64'(e.head));
                chk("commit_count", 64'(cu_bus.commit_count), 64'(e.cnt));
                chk("commit_valid", 64'(cu_bus.commit_valid), 64'(e.cv));
                chk("reg_we", 64'(cu_bus.reg_we), 64'(e.we));
                for (int k = 0; k < CW; k++)
                    chk($sformatf("lane%0d_addr_data_tag", k),
                        64'({cu_bus.reg_addr[k], cu_bus.reg_data[k], cu_bus.commit_tags[k]}),
                        64'({e.addr[k], e.data[k], e.tag[k]}));
                chk("store_valid_mode", 64'({cu_bus.store_valid, cu_bus.store_mode}), 64'({e.sv, e.mode}));
                chk("store_addr_data", {cu_bus.store_addr, cu_bus.store_data}, {e.saddr, e.sdata});
                if (cu_bus.commit_count != 0 || cu_bus.store_valid)
                    $display("t=%0t head=%0d count=%0d valid=%b we=%b store_valid=%b addr=%h",
                             $time, cu_bus.head_tag, cu_bus.commit_count, cu_bus.commit_valid,
                             cu_bus.reg_we, cu_bus.store_valid, cu_bus.store_addr);
            end
        end
    end

    initial begin
        for (int s = 0; s < NB; s++) begin
            rob[s] = '0;
            cu_bus.entries[s] = '0;
        end
        tail = 0; m_head = 0; m_sv = 1'b0; m_mode = WORD; m_saddr = '0; m_sdata = '0;
        rst = 1'b1; cu_bus.flush = 1'b0; cu_bus.flush_tag = '0; cu_bus.store_ready = 1'b1;
        rst_i = 1'b1; flush_i = 1'b0; ftag_i = '0; sready_i = 1'b1;

        repeat (3) cycle(0);
        after_edge();
        chk("reset_head", 64'(cu_bus.head_tag), 64'd0);
        chk("reset_mode", 64'(cu_bus.store_mode), 64'(WORD));
        rst_i = 1'b0;

        // four ALU results from head 0
        for (int i = 0; i < 4; i++) rob[i] = mk_entry(ALU, i, i + 1, 32'(100 + i));
        cycle(0);
        after_edge();
        chk("full_count", 64'(cu_bus.commit_count), 64'd4);
        chk("full_we", 64'(cu_bus.reg_we), 64'hf);
        chk("full_head", 64'(cu_bus.head_tag), 64'd4);

        // hole at the third lane stops the run
        for (int i = 4; i < 8; i++) rob[i] = mk_entry(ALU, i, i, 32'(200 + i));
        rob[6].e_state = S_ISSUED;
        cycle(0);
        after_edge();
        chk("hole_count", 64'(cu_bus.commit_count), 64'd2);
        chk("hole_head", 64'(cu_bus.head_tag), 64'd6);

        // window crossing slot 7 -> 0 with wrapped tags 8, 9
        rob[6].e_state = S_EXECUTED;
        rob[0] = mk_entry(ALU, 8, 9, 32'd300);
        rob[1] = mk_entry(ALU, 9, 10, 32'd301);
        cycle(0);
        after_edge();
        chk("wrap_count", 64'(cu_bus.commit_count), 64'd4);
        chk("wrap_head", 64'(cu_bus.head_tag), 64'd10);

        // stale tag in the third lane
        rob[2] = mk_entry(ALU, 10, 3, 32'd400);
        rob[3] = mk_entry(ALU, 11, 4, 32'd401);
        rob[4] = mk_entry(ALU, 4, 5, 32'd402);
        cycle(0);
        after_edge();
        chk("stale_count", 64'(cu_bus.commit_count), 64'd2);

        // back-to-back stores with a slow store buffer
        rob[4] = mk_entry(STORE, 12, 0, 32'h500);
        rob[5] = mk_entry(STORE, 13, 0, 32'h600);
        sready_i = 1'b0;
        cycle(0);
        after_edge();
        chk("st1_count", 64'(cu_bus.commit_count), 64'd1);
        chk("st1_addr", 64'(cu_bus.store_addr), 64'h1500);
        repeat (3) cycle(0);
        sready_i = 1'b1;
        cycle(0);
        after_edge();
        chk("st2_addr", 64'(cu_bus.store_addr), 64'h1600);
        cycle(0);

        // zero destination retires without a register write
        rob[6] = mk_entry(ALU, 14, 0, 32'h77);
        cycle(0);
        after_edge();
        chk("dest0_valid", 64'(cu_bus.commit_valid), 64'd1);
        chk("dest0_we_addr", 64'({cu_bus.reg_we, cu_bus.reg_addr[0]}), 64'd0);

        // flush while a store is stuck
        rob[7] = mk_entry(STORE, 15, 0, 32'h900);
        sready_i = 1'b0;
        repeat (3) cycle(0);
        flush_i = 1'b1; ftag_i = 4'd5;
        cycle(0);
        flush_i = 1'b0;
        after_edge();
        chk("flush_sv", 64'(cu_bus.store_valid), 64'd0);
        chk("flush_head", 64'(cu_bus.head_tag), 64'd5);
        chk("flush_cv", 64'(cu_bus.commit_valid), 64'd0);

        // reset in the middle of random traffic
        repeat (20) cycle(1);
        rst_i = 1'b1; flush_i = 1'b0; sready_i = 1'b1;
        cycle(0);
        rst_i = 1'b0;
        after_edge();
        chk("midrst_head", 64'(cu_bus.head_tag), 64'd0);
        chk("midrst_out", 64'({cu_bus.commit_valid, cu_bus.store_valid, cu_bus.commit_count}), 64'd0);

        repeat (800) cycle(1);

        after_edge();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
